mad_array_sequencer: RTL and testbench
======================================

// Module: mad_array_sequencer
// PURPOSE
//  Sequential front/back stage for the combinational multiply/divide cell array.
//  - Accepts one operation per valid/ready handshake.
//  - Registers the operands and drives them, with MUL_BAR, onto the array inputs.
//  - Waits a fixed ripple-settle time, then captures the array outputs and presents them on a valid/ready result port.
//  - Sits between the datapath client and the CELL array; owns all timing, since the array has no clock.
// PARAMETERS
//  N              4   operand width: multiplier/divisor N bits, product/dividend 2N bits
//  SETTLE_CYCLES  4   cycles operands are held stable before capture (>=1; sized to array ripple depth)
// PORTS
//  CLK        in   1    single clock, rising edge
//  RST        in   1    synchronous, active-high reset
//  REQ_VALID  in   1    request valid
//  REQ_READY  out  1    block can accept a request
//  REQ_MUL    in   1    1 = multiply, 0 = divide
//  REQ_A      in   2N   multiply: A[N-1:0] multiplicand (upper half ignored); divide: dividend
//  REQ_B      in   N    multiply: multiplier; divide: divisor
//  ARR_X      out  N    array X_IN bus (multiplicand / divisor)
//  ARR_Y      out  N    array Y_ROW bus (multiplier bits)
//  ARR_P      out  2N   array P bus (dividend; 0 in multiply)
//  ARR_MUL_BAR out 1    0 = multiply, 1 = divide (array mode select)
//  ARR_PROD   in   2N   array product output
//  ARR_Q      in   N    array quotient output
//  ARR_R      in   N    array remainder output
//  RES_VALID  out  1    result valid
//  RES_READY  in   1    consumer accepts result
//  RES_DATA   out  2N   multiply: product; divide: {remainder, quotient}
//  RES_OVF    out  1    divide overflow: dividend[2N-1:N] >= divisor
//  RES_DZ     out  1    divide-by-zero flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: all outputs 0, except REQ_READY = 1.
//    State = IDLE, counter = 0, operand and result registers = 0.
//  - FSM states: IDLE -> SETTLE -> HOLD -> IDLE.
//  - IDLE:
//    - REQ_READY = 1.
//    - On REQ_VALID at an edge: register mode and operands, drive ARR_* from those registers, load counter = SETTLE_CYCLES-1, go to SETTLE.
//  - SETTLE:
//    - REQ_READY = 0; ARR_* held constant.
//    - Counter decrements each cycle.
//    - At the edge where counter == 0: capture ARR_PROD or {ARR_R, ARR_Q} into RES_DATA, set RES_VALID, go to HOLD.
//  - Latency: RES_VALID rises exactly SETTLE_CYCLES+1 edges after the accepting edge.
//  - HOLD:
//    - RES_VALID = 1; RES_DATA/RES_OVF/RES_DZ are stable; ARR_* keep their last values.
//    - On RES_READY: RES_VALID -> 0 and go to IDLE; REQ_READY = 1 the following cycle.
//    - No request overlap: throughput is at most one operation per SETTLE_CYCLES+2 cycles.
//  - Arithmetic:
//    - Multiply: unsigned, N x N -> 2N; RES_OVF = 0 always.
//    - Divide: unsigned, 2N / N. RES_OVF is computed from the registered operands at capture.
//    - When RES_OVF = 1, RES_DATA is whatever the array produced; consumers must discard it.
//  - RES_VALID/RES_READY asserted in the same cycle as a new REQ_VALID: the request is not accepted until IDLE.
//  - RST in any state: returns to IDLE on that edge. In-flight operation is dropped with no result; RES_VALID = 0.
// CONFIGURATION
//  MAD_DIVZERO_DETECT_EN defined:
//    - A divide with REQ_B == 0 bypasses SETTLE: the accepting edge goes directly to HOLD.
//    - RES_VALID asserts 1 edge later.
//    - RES_DZ = 1, RES_OVF = 0, RES_DATA = {REQ_A[N-1:0], {N{1'b1}}}.
//  Not defined:
//    - RES_DZ is tied 0.
//    - Divisor 0 takes the normal path and reports RES_OVF = 1 (since high half >= 0).
// TESTING (N=4, SETTLE_CYCLES=4)
//  1. MUL, A=0x0D, B=0xB -> RES_DATA=0x8F, RES_OVF=0; RES_VALID 5 edges after accept.
//  2. DIV, A=0x64, B=0x7 -> RES_DATA=0x2E (R=2, Q=14), RES_OVF=0.
//  3. DIV, A=0x80, B=0x3 -> RES_OVF=1.
//  4. Result backpressure: RES_READY=0 for 6 cycles -> RES_DATA stable, REQ_READY=0 throughout.
//     Then RES_READY=1 -> IDLE, REQ_READY=1 on the next cycle.
//  5. Assert RST 2 cycles into SETTLE -> next cycle REQ_READY=1, RES_VALID=0; no result is ever produced.
//  6. DIV, A=0x25, B=0.
//     With MAD_DIVZERO_DETECT_EN: RES_VALID 1 edge after accept, RES_DZ=1, RES_DATA=0x5F.
//     Without it: RES_OVF=1 after 5 edges.

Source files
------------

// File: rtl/mad_array_sequencer.sv
// mad_array_sequencer: clocked front/back stage for the combinational multiply/divide array (optional MAD_DIVZERO_DETECT_EN)
module mad_array_sequencer #(
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_mul,
    input  logic [2*N-1:0] req_a,
    input  logic [N-1:0]   req_b,
    output logic [N-1:0]   arr_x,
    output logic [N-1:0]   arr_y,
    output logic [2*N-1:0] arr_p,
    output logic           arr_mul_bar,
    input  logic [2*N-1:0] arr_prod,
    input  logic [N-1:0]   arr_q,
    input  logic [N-1:0]   arr_r,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res_data,
    output logic           res_ovf,
    output logic           res_dz
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic           mul_bar;
    logic [2*N-1:0] a_r;
    logic [N-1:0]   b_r;
    logic           accept, dz;

    assign accept = (state == IDLE) && req_valid;
`ifdef MAD_DIVZERO_DETECT_EN
    assign dz = !req_mul && (req_b == '0);
`else
    assign dz = 1'b0;
`endif

    // mode register reset to multiply keeps every array output at 0 after reset
    assign arr_mul_bar = mul_bar;
    assign arr_x       = mul_bar ? b_r : a_r[N-1:0];
    assign arr_y       = mul_bar ? '0 : b_r;
    assign arr_p       = mul_bar ? a_r : '0;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx  = state;
        req_ready = state == IDLE;
        res_valid = state == HOLD;
        case (state)
            IDLE:    if (req_valid) state_nx = dz ? HOLD : SETTLE;
            SETTLE:  if (cnt == '0) state_nx = HOLD;
            HOLD:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand capture, settle countdown and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mul_bar  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            res_data <= '0;
            res_ovf  <= 1'b0;
            res_dz   <= 1'b0;
        end else if (accept) begin
            mul_bar <= !req_mul;
            a_r     <= req_a;
            b_r     <= req_b;
            cnt     <= CW'(SETTLE_CYCLES - 1);
            if (dz) begin
                res_data <= {req_a[N-1:0], {N{1'b1}}};
                res_ovf  <= 1'b0;
                res_dz   <= 1'b1;
            end
        end else if (state == SETTLE) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                res_data <= mul_bar ? {arr_r, arr_q} : arr_prod;
                res_ovf  <= mul_bar && (a_r[2*N-1:N] >= b_r);
                res_dz   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mad_array_sequencer.sv
// tb_mad_array_sequencer: randomized self-checking bench with a behavioural array and result model
module tb_mad_array_sequencer;
    localparam int N = 4;
    localparam int S = 4;

    logic         clk, rst, req_valid, req_ready, req_mul;
    logic [7:0]   req_a;
    logic [3:0]   req_b;
    logic [3:0]   arr_x, arr_y, arr_q, arr_r;
    logic [7:0]   arr_p, arr_prod;
    logic         arr_mul_bar, res_valid, res_ready, res_ovf, res_dz;
    logic [7:0]   res_data;
    int           checks = 0;
    int           errors = 0;

    mad_array_sequencer #(.N(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mul(req_mul), .req_a(req_a), .req_b(req_b),
        .arr_x(arr_x), .arr_y(arr_y), .arr_p(arr_p), .arr_mul_bar(arr_mul_bar),
        .arr_prod(arr_prod), .arr_q(arr_q), .arr_r(arr_r),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_dz(res_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural stand-in for the combinational cell array
    always_comb begin
        arr_prod = 8'({4'b0, arr_x} * {4'b0, arr_y});
        arr_q    = (arr_x == 4'd0) ? 4'hF : 4'(arr_p / {4'b0, arr_x});
        arr_r    = (arr_x == 4'd0) ? 4'h0 : 4'(arr_p % {4'b0, arr_x});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // one operation from request to release, checked against arithmetic expectations
    task automatic run_op(input bit mul, input logic [7:0] a, input logic [3:0] b,
                          input int bp, input bit overlap);
        int          edges, exp_lat;
        bit          dz_path, exp_ovf, exp_dz, chk_data;
        logic [7:0]  exp_data, held;
`ifdef MAD_DIVZERO_DETECT_EN
        dz_path = !mul && b == 4'd0;
`else
        dz_path = 1'b0;
`endif
        exp_lat  = dz_path ? 1 : S + 1;
        exp_dz   = dz_path;
        exp_ovf  = !mul && !dz_path && (a / 16) >= b;
        chk_data = !exp_ovf;
        exp_data = mul ? 8'(a[3:0] * b)
                 : dz_path ? {a[3:0], 4'hF}
                 : (b == 4'd0) ? 8'h00 : {4'(a % b), 4'(a / b)};
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_mul = mul; req_a = a; req_b = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        req_valid = 1'b0; req_mul = 1'($urandom); req_a = 8'($urandom); req_b = 4'($urandom);
        while (!res_valid && edges < 20) begin
            chk("req_ready_busy", req_ready, 0);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", edges, exp_lat);
        if (chk_data) chk("res_data", res_data, exp_data);
        chk("res_ovf", res_ovf, exp_ovf);
        chk("res_dz", res_dz, exp_dz);
        chk("arr_bus", {arr_mul_bar, arr_x, arr_y, arr_p},
            {!mul, mul ? a[3:0] : b, mul ? b : 4'd0, mul ? 8'd0 : a});
        held = res_data;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_stable", res_data, held);
        end
        res_ready = 1'b1;
        if (overlap) begin
            req_valid = 1'b1; req_mul = 1'b1; req_a = 8'h11; req_b = 4'h1;
        end
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = 1'b0;
        chk("release_valid", res_valid, 0);
        chk("release_ready", req_ready, 1);
    endtask

    // reset two cycles into settle must drop the operation silently
    task automatic reset_mid_settle();
        int seen;
        req_valid = 1'b1; req_mul = 1'b1; req_a = 8'h0D; req_b = 4'hB;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", res_valid, 0);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("rst_no_result", seen, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_mul = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", req_ready, 1);
        chk("reset_outs", {res_valid, res_data, res_ovf, res_dz}, 0);
        chk("reset_arr", {arr_mul_bar, arr_x, arr_y, arr_p}, 0);
        run_op(1'b1, 8'h0D, 4'hB, 0, 1'b0);
        run_op(1'b0, 8'h64, 4'h7, 0, 1'b0);
        run_op(1'b0, 8'h80, 4'h3, 0, 1'b0);
        run_op(1'b1, 8'hFF, 4'hF, 6, 1'b1);
        reset_mid_settle();
        run_op(1'b0, 8'h25, 4'h0, 1, 1'b0);
        run_op(1'b0, 8'h0F, 4'h1, 0, 1'b0);
        run_op(1'b0, 8'hEF, 4'hF, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            run_op(1'($urandom), 8'($urandom),
                   ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
